// File: rtl/rv_decode_queue_pkg.sv
// rtl/rv_decode_queue_pkg.sv - shared RV32I opcodes, immediate formats and queue entry sizing
package rv_decode_queue_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  localparam int ENTRY_FLAGS = 6;

  // opcode + funct3 + funct7 + three register indices + imm + nextpc + flag bits
  function automatic int entry_width(int xlen, int raw);
    return 7 + 3 + 7 + 3 * raw + 2 * xlen + ENTRY_FLAGS;
  endfunction

endpackage

// File: rtl/rv_decode_queue_if.sv
// rtl/rv_decode_queue_if.sv - fetch-side and issue-side signals of the decode queue
interface rv_decode_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int RAW   = 5
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            if_id_valid;
  logic [31:0]     if_id_instruc;
  logic [XLEN-1:0] if_id_nextpc;
  logic            id_if_ready;
  logic            flush;
  logic            id_iss_valid;
  logic            id_iss_ready;
  logic [6:0]      id_iss_opcode;
  logic [2:0]      id_iss_funct3;
  logic [6:0]      id_iss_funct7;
  logic [RAW-1:0]  id_iss_addra;
  logic [RAW-1:0]  id_iss_addrb;
  logic [RAW-1:0]  id_iss_regdest;
  logic [XLEN-1:0] id_iss_imedext;
  logic [XLEN-1:0] id_iss_nextpc;
  logic            id_iss_check_a;
  logic            id_iss_check_b;
  logic            id_iss_writereg;
  logic            id_iss_readmem;
  logic            id_iss_writemem;
  logic            id_iss_illegal;
  logic [CW-1:0]   id_count;

  modport master (
    output if_id_valid, if_id_instruc, if_id_nextpc, flush, id_iss_ready,
    input  id_if_ready, id_iss_valid, id_iss_opcode, id_iss_funct3, id_iss_funct7,
           id_iss_addra, id_iss_addrb, id_iss_regdest, id_iss_imedext, id_iss_nextpc,
           id_iss_check_a, id_iss_check_b, id_iss_writereg, id_iss_readmem,
           id_iss_writemem, id_iss_illegal, id_count
  );

  modport slave (
    input  if_id_valid, if_id_instruc, if_id_nextpc, flush, id_iss_ready,
    output id_if_ready, id_iss_valid, id_iss_opcode, id_iss_funct3, id_iss_funct7,
           id_iss_addra, id_iss_addrb, id_iss_regdest, id_iss_imedext, id_iss_nextpc,
           id_iss_check_a, id_iss_check_b, id_iss_writereg, id_iss_readmem,
           id_iss_writemem, id_iss_illegal, id_count
  );
endinterface

// File: rtl/rv_imm_gen.sv
// rtl/rv_imm_gen.sv - RV32I immediate extraction and format classification
module rv_imm_gen
  import rv_decode_queue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt
);

  logic [31:0] imm32;

  always_comb begin
    fmt   = FMT_NONE;
    imm32 = '0;
    case (instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        fmt   = FMT_I;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_OP: fmt = FMT_R;
      default: ;
    endcase
  end

  // wider datapaths keep the RV32 immediate sign-extended
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/rv_decode_queue.sv
// rtl/rv_decode_queue.sv - RV32I decode stage feeding an in-order micro-op FIFO
module rv_decode_queue
  import rv_decode_queue_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int RAW   = 5
) (
  input  logic             clock,
  input  logic             reset,
  rv_decode_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = entry_width(XLEN, RAW);

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [RAW-1:0]  addra;
    logic [RAW-1:0]  addrb;
    logic [RAW-1:0]  regdest;
    logic [XLEN-1:0] imedext;
    logic [XLEN-1:0] nextpc;
    logic            check_a;
    logic            check_b;
    logic            writereg;
    logic            readmem;
    logic            writemem;
    logic            illegal;
  } entry_t;

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [XLEN-1:0] imm;
  imm_fmt_e        fmt;
  entry_t          entry_in;
  entry_t          head;

  logic [EW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic            ready_q;
  logic            valid;
  logic            enq;
  logic            deq;

  assign instr  = bus.if_id_instruc;
  assign opcode = instr[6:0];

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (instr),
    .imm   (imm),
    .fmt   (fmt)
  );

  always_comb begin
    entry_in          = '0;
    entry_in.opcode   = opcode;
    entry_in.funct3   = instr[14:12];
    entry_in.funct7   = instr[31:25];
    entry_in.addra    = RAW'(instr[19:15]);
    entry_in.addrb    = RAW'(instr[24:20]);
    entry_in.regdest  = RAW'(instr[11:7]);
    entry_in.imedext  = imm;
    entry_in.nextpc   = bus.if_id_nextpc;
    entry_in.illegal  = (fmt == FMT_NONE);
    entry_in.check_a  = !(entry_in.illegal || opcode == OPC_LUI ||
                          opcode == OPC_AUIPC || opcode == OPC_JAL);
    entry_in.check_b  = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    entry_in.writereg = ((opcode == OPC_OP) || (opcode == OPC_OP_IMM) || (opcode == OPC_LOAD) ||
                         (opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL) ||
                         (opcode == OPC_JALR)) && (instr[11:7] != 5'd0);
    entry_in.readmem  = (opcode == OPC_LOAD);
    entry_in.writemem = (opcode == OPC_STORE);
  end

  assign valid = (count != '0);
  // ready is registered, so a full queue never enqueues even while draining
  assign enq   = bus.if_id_valid && ready_q && !bus.flush;
  assign deq   = valid && bus.id_iss_ready && !bus.flush;

  always_comb begin
    count_nxt = count;
    case ({enq, deq})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b1;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b1;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      count   <= count_nxt;
      ready_q <= (count_nxt != CW'(DEPTH));
    end
  end

  always_ff @(posedge clock) begin
    if (enq) mem[wr_ptr] <= entry_in;
  end

  assign head = valid ? entry_t'(mem[rd_ptr]) : '0;

  assign bus.id_if_ready     = ready_q;
  assign bus.id_iss_valid    = valid;
  assign bus.id_count        = count;
  assign bus.id_iss_opcode   = head.opcode;
  assign bus.id_iss_funct3   = head.funct3;
  assign bus.id_iss_funct7   = head.funct7;
  assign bus.id_iss_addra    = head.addra;
  assign bus.id_iss_addrb    = head.addrb;
  assign bus.id_iss_regdest  = head.regdest;
  assign bus.id_iss_imedext  = head.imedext;
  assign bus.id_iss_nextpc   = head.nextpc;
  assign bus.id_iss_check_a  = head.check_a;
  assign bus.id_iss_check_b  = head.check_b;
  assign bus.id_iss_writereg = head.writereg;
  assign bus.id_iss_readmem  = head.readmem;
  assign bus.id_iss_writemem = head.writemem;
  assign bus.id_iss_illegal  = head.illegal;

endmodule

// File: tb/tb_rv_decode_queue.sv
// tb/tb_rv_decode_queue.sv - directed and random checks of rv_decode_queue against a queue model
module tb_rv_decode_queue;

  typedef struct {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] npc;
    logic        ca;
    logic        cb;
    logic        wr;
    logic        rm;
    logic        wm;
    logic        ill;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t mq[$];
  logic [6:0] opc_tab [11] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37,
                               7'h17, 7'h6F, 7'h33, 7'h7F, 7'h0B};

  always #5 clock = ~clock;

  rv_decode_queue_if #(.XLEN(32), .DEPTH(4), .RAW(5)) bus ();

  rv_decode_queue #(.XLEN(32), .DEPTH(4), .RAW(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  function automatic exp_t model_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    logic [31:0] sgn;
    logic [6:0]  op;
    logic        legal;
    op       = w[6:0];
    sgn      = w[31] ? 32'hFFFF_FFFF : 32'h0;
    e.opcode = op;
    e.funct3 = w[14:12];
    e.funct7 = w[31:25];
    e.ra     = w[19:15];
    e.rb     = w[24:20];
    e.rd     = w[11:7];
    e.npc    = pc;
    case (op)
      7'h13, 7'h03, 7'h67: e.imm = (sgn << 11) | 32'(w[30:20]);
      7'h23:               e.imm = (sgn << 11) | (32'(w[30:25]) << 5) | 32'(w[11:7]);
      7'h63:               e.imm = (sgn << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      7'h37, 7'h17:        e.imm = w & 32'hFFFF_F000;
      7'h6F:               e.imm = (sgn << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      default:             e.imm = 32'h0;
    endcase
    legal = op inside {7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    e.ill = !legal;
    e.ca  = legal && !(op inside {7'h37, 7'h17, 7'h6F});
    e.cb  = op inside {7'h33, 7'h23, 7'h63};
    e.wr  = legal && !(op inside {7'h23, 7'h63}) && (w[11:7] != 5'd0);
    e.rm  = (op == 7'h03);
    e.wm  = (op == 7'h23);
    return e;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    r = $urandom();
    return {r[31:7], opc_tab[$urandom_range(0, 10)]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag);
    exp_t e;
    if (mq.size() != 0) e = mq[0];
    else e = '{default: '0};
    chk({tag, ".valid"},  32'(bus.id_iss_valid), 32'(mq.size() != 0));
    chk({tag, ".ready"},  32'(bus.id_if_ready), 32'(mq.size() < 4));
    chk({tag, ".count"},  32'(bus.id_count), 32'(mq.size()));
    chk({tag, ".opcode"}, 32'(bus.id_iss_opcode), 32'(e.opcode));
    chk({tag, ".funct3"}, 32'(bus.id_iss_funct3), 32'(e.funct3));
    chk({tag, ".funct7"}, 32'(bus.id_iss_funct7), 32'(e.funct7));
    chk({tag, ".addra"},  32'(bus.id_iss_addra), 32'(e.ra));
    chk({tag, ".addrb"},  32'(bus.id_iss_addrb), 32'(e.rb));
    chk({tag, ".rd"},     32'(bus.id_iss_regdest), 32'(e.rd));
    chk({tag, ".imm"},    bus.id_iss_imedext, e.imm);
    chk({tag, ".nextpc"}, bus.id_iss_nextpc, e.npc);
    chk({tag, ".flags"},
        32'({bus.id_iss_check_a, bus.id_iss_check_b, bus.id_iss_writereg,
             bus.id_iss_readmem, bus.id_iss_writemem, bus.id_iss_illegal}),
        32'({e.ca, e.cb, e.wr, e.rm, e.wm, e.ill}));
  endtask

  // one clock: drive after a falling edge, update model at the rising edge, check at the next falling edge
  task automatic step(input logic v, input logic [31:0] w, input logic r, input logic f, input string tag);
    logic [31:0] pc;
    bit acc;
    bit deq;
    pc = $urandom() & 32'hFFFF_FFFC;
    bus.if_id_valid   = v;
    bus.if_id_instruc = w;
    bus.if_id_nextpc  = pc;
    bus.id_iss_ready  = r;
    bus.flush         = f;
    acc = v && (mq.size() < 4) && !f;
    deq = (mq.size() != 0) && r && !f;
    @(posedge clock);
    if (f) mq.delete();
    else begin
      if (deq) void'(mq.pop_front());
      if (acc) mq.push_back(model_decode(w, pc));
    end
    @(negedge clock);
    bus.if_id_valid  = 1'b0;
    bus.id_iss_ready = 1'b0;
    bus.flush        = 1'b0;
    check_head(tag);
  endtask

  initial begin
    bus.if_id_valid   = 1'b0;
    bus.if_id_instruc = '0;
    bus.if_id_nextpc  = '0;
    bus.id_iss_ready  = 1'b0;
    bus.flush         = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_head("reset");
    reset = 1'b1;

    step(1'b1, 32'hFFD0_8293, 1'b0, 1'b0, "addi");
    chk("addi.imm_const", bus.id_iss_imedext, 32'hFFFF_FFFD);
    chk("addi.rd_const", 32'(bus.id_iss_regdest), 32'd5);
    chk("addi.wr_cb", 32'({bus.id_iss_writereg, bus.id_iss_check_b}), 32'b10);
    step(1'b0, 32'h0, 1'b1, 1'b0, "addi_deq");

    // beq x0,x0,-4
    step(1'b1, 32'hFE00_0EE3, 1'b0, 1'b0, "beq");
    chk("beq.imm_const", bus.id_iss_imedext, 32'hFFFF_FFFC);
    chk("beq.wr_ca_cb", 32'({bus.id_iss_writereg, bus.id_iss_check_a, bus.id_iss_check_b}), 32'b011);
    step(1'b0, 32'h0, 1'b1, 1'b0, "beq_deq");

    step(1'b1, 32'h0000_006F, 1'b0, 1'b0, "jal_x0");
    chk("jal_x0.writereg", 32'(bus.id_iss_writereg), 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0, "jal_deq");

    step(1'b1, 32'h0000_007F, 1'b0, 1'b0, "illegal");
    chk("illegal.flags", 32'({bus.id_iss_illegal, bus.id_iss_writereg}), 32'b10);
    chk("illegal.imm", bus.id_iss_imedext, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, "illegal_deq");

    for (int i = 0; i < 5; i++) step(1'b1, rand_word(), 1'b0, 1'b0, "fill");
    chk("full.count", 32'(bus.id_count), 32'd4);
    chk("full.ready", 32'(bus.id_if_ready), 32'd0);

    for (int i = 0; i < 9; i++) step(1'b1, rand_word(), 1'b1, 1'b0, "pair");
    for (int i = 0; i < 8 && mq.size() != 0; i++) step(1'b0, 32'h0, 1'b1, 1'b0, "drain");

    for (int i = 0; i < 3; i++) step(1'b1, rand_word(), 1'b0, 1'b0, "pre_flush");
    chk("pre_flush.count", 32'(bus.id_count), 32'd3);
    step(1'b1, rand_word(), 1'b1, 1'b1, "flush");
    chk("flush.count_valid", 32'({bus.id_count, bus.id_iss_valid}), 32'd0);
    step(1'b1, rand_word(), 1'b0, 1'b0, "post_flush");
    step(1'b1, rand_word(), 1'b0, 1'b0, "post_flush2");
    chk("pre_reset.count", 32'(bus.id_count), 32'd2);

    reset = 1'b0;
    #1;
    chk("async_rst.valid", 32'(bus.id_iss_valid), 32'd0);
    chk("async_rst.ready", 32'(bus.id_if_ready), 32'd1);
    chk("async_rst.fields", bus.id_iss_imedext | bus.id_iss_nextpc | 32'(bus.id_iss_opcode), 32'd0);
    mq.delete();
    check_head("async_rst");
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, rand_word(), 1'($urandom_range(0, 1)),
           $urandom_range(0, 19) == 0, "random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
